// File: rtl/xor_pkg.sv
// Shared definitions for the XOR-block family: FSM state encodings used by
// the stream-compare stages.
package xor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage : xor_pkg

// File: rtl/frame_bit_counter.sv
// Tracks the index of the next qualified bit within a frame and flags the
// terminal bit so the controller can close the frame on that beat.
module frame_bit_counter #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic last_bit_o
);

  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign last_bit_o = (idx_q == CNT_W'(FRAME_LEN - 1));

endmodule : frame_bit_counter

// File: rtl/xor_mismatch_counter.sv
// Counts asserted XOR results (Hamming distance) over a frame of FRAME_LEN
// qualified bits and presents the total with a done/out_ready handshake.
module xor_mismatch_counter
  import xor_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             y_in,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_cnt
);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic start_frame;
  logic accept;
  logic last_bit;

  // A frame may open from IDLE, or straight out of HOLD when the result is
  // consumed in the same cycle (back-to-back frames).
  assign start_frame = start && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_HOLD) && out_ready));
  assign accept      = (state_q == ST_RUN) && bit_valid;

  frame_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_frame_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (start_frame),
    .inc_i      (accept),
    .last_bit_o (last_bit)
  );

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (accept && last_bit) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and accumulator next values; y_in is only looked at on accepted
  // beats, so X on it during stalls cannot reach the count.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_HOLD);
    cnt_d  = cnt_q;
    if (start_frame) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(y_in);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mismatch_cnt = cnt_q;

endmodule : xor_mismatch_counter
